// File: rtl/stepper_pkg.sv
// Shared types, constants and the speed whitelist for the stepper command sequencer.
// STEPPER_HOMING_EN adds SPEED_HOME to the accepted speeds.
package stepper_pkg;

    localparam int POS_W   = 24;
    localparam int SPEED_W = 8;
    localparam logic [SPEED_W-1:0] SPEED_HOME = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MOVE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HOME   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic [POS_W-1:0]   goal;
    } stepper_cmd_t;

    function automatic logic speed_valid(input logic [SPEED_W-1:0] speed);
        logic ok;
        ok = ((speed >= 8'd1) && (speed <= 8'd40)) ||
             (speed == 8'd45) || (speed == 8'd50) || (speed == 8'd55);
`ifdef STEPPER_HOMING_EN
        ok = ok || (speed == SPEED_HOME);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/stepper_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO with flush; occupancy is kept as an explicit counter.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == (AW+1)'(DEPTH));
    assign empty     = (level_r == (AW+1)'(0));
    assign level     = level_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/stepper_cmd_sequencer.sv
// Buffers {speed, goal} commands and issues them one at a time to the stepper driver.
// Define STEPPER_HOMING_EN to compile in the HOME state and home_switch synchroniser.
module stepper_cmd_sequencer
    import stepper_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_data,
    input  logic                   abort,
    input  logic                   step,
    input  logic                   dir,
    input  logic                   home_switch,
    output logic [31:0]            control,
    output logic                   homing_enable,
    output logic                   stepper_rst,
    output logic [POS_W-1:0]       position,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    seq_state_t         state_r;
    stepper_cmd_t       ctrl_r;
    stepper_cmd_t       head_s;
    logic [POS_W-1:0]   pos_r;
    logic [CW-1:0]      settle_cnt_r;
    logic               done_r;
    logic               err_r;
    logic               busy_r;
    logic               step_r;
    logic               ready_en_r;
    logic               full_s;
    logic               empty_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               step_rise_s;

    assign accept_s    = cmd_valid & cmd_ready;
    assign push_s      = accept_s & speed_valid(cmd_data[31:24]) & ~abort;
    assign pop_s       = (state_r == ST_LOAD) & ~abort;
    assign step_rise_s = step & ~step_r;

    assign cmd_ready = ready_en_r & ~full_s;
    assign control   = ctrl_r;
    assign position  = pos_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (abort),
        .push    (push_s),
        .pop     (pop_s),
        .din     (cmd_data),
        .dout    (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level)
    );

`ifdef STEPPER_HOMING_EN
    logic       hen_r;
    logic [1:0] hrst_cnt_r;
    logic       sync1_r;
    logic       sync2_r;

    assign homing_enable = hen_r;
    assign stepper_rst   = ~reset_n | (hrst_cnt_r != 2'd0);

    // Two-flop synchroniser for the asynchronous limit switch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= home_switch;
            sync2_r <= sync1_r;
        end
    end
`else
    logic unused_home_s;
    assign unused_home_s = home_switch;
    assign homing_enable = 1'b0;
    assign stepper_rst   = ~reset_n;
`endif

    // Step edge detector, reject pulse and post-reset ready enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step_r     <= 1'b0;
            err_r      <= 1'b0;
            ready_en_r <= 1'b0;
        end else begin
            step_r     <= step;
            err_r      <= accept_s & ~speed_valid(cmd_data[31:24]);
            ready_en_r <= 1'b1;
        end
    end

    // Sequencer FSM: command issue, position tracking, settle timing and abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            ctrl_r       <= 32'd0;
            pos_r        <= 24'd0;
            settle_cnt_r <= CW'(0);
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
`ifdef STEPPER_HOMING_EN
            hen_r        <= 1'b0;
            hrst_cnt_r   <= 2'd0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef STEPPER_HOMING_EN
            if (hrst_cnt_r != 2'd0) begin
                hrst_cnt_r <= hrst_cnt_r - 2'd1;
            end
`endif
            if (abort) begin
                // Park the stepper where it is; queued work is discarded by the FIFO flush.
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                ctrl_r.goal <= pos_r;
`ifdef STEPPER_HOMING_EN
                hen_r       <= 1'b0;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        ctrl_r.goal <= pos_r;
                        if (!empty_s) begin
                            state_r <= ST_LOAD;
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
`ifdef STEPPER_HOMING_EN
                        if (head_s.speed == SPEED_HOME) begin
                            state_r <= ST_HOME;
                            hen_r   <= 1'b1;
                        end else begin
                            ctrl_r  <= head_s;
                            state_r <= ST_MOVE;
                        end
`else
                        ctrl_r  <= head_s;
                        state_r <= ST_MOVE;
`endif
                    end
                    ST_MOVE: begin
                        if (pos_r == ctrl_r.goal) begin
                            state_r      <= ST_SETTLE;
                            settle_cnt_r <= CW'(0);
                        end else if (step_rise_s) begin
                            pos_r <= dir ? (pos_r - POS_W'(1)) : (pos_r + POS_W'(1));
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_r == CW'(SETTLE_CYCLES - 1)) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + CW'(1);
                        end
                    end
`ifdef STEPPER_HOMING_EN
                    ST_HOME: begin
                        if (sync2_r) begin
                            hen_r        <= 1'b0;
                            hrst_cnt_r   <= 2'd2;
                            pos_r        <= 24'd0;
                            ctrl_r       <= 32'd0;
                            settle_cnt_r <= CW'(0);
                            state_r      <= ST_SETTLE;
                        end
                    end
`endif
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
